fp16_unpack: RTL and testbench

FP16_UNPACK -- requirements
Module: fp16_unpack

---
 rtl/fp16_unpack_if.sv | 23 ++
 rtl/fp16_unpack.sv | 152 +++++++++++++++
 tb/tb_fp16_unpack.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fp16_unpack_if.sv
// Operand/result handshake bundle for the FP16 unpack stage.
interface fp16_unpack_if;
    logic        in_valid;
    logic        in_sign;
    logic [4:0]  in_exp;
    logic [9:0]  in_mant;
    logic        out_valid;
    logic        out_sign;
    logic [6:0]  out_exp;
    logic [10:0] out_sig;
    logic [2:0]  out_class;
    logic        busy;

    modport master (
        output in_valid, in_sign, in_exp, in_mant,
        input  out_valid, out_sign, out_exp, out_sig, out_class, busy
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant,
        output out_valid, out_sign, out_exp, out_sig, out_class, busy
    );
endinterface

// File: rtl/fp16_unpack.sv
// FP16 unpack: classify, unbias exponent, expose hidden bit, optionally normalize subnormals.
// Macro FP16_SUBNORM_NORMALIZE_EN enables iterative subnormal normalization; otherwise subnormals flush to zero.
//
// state | meaning
// IDLE  | accepting operands; non-subnormal results registered on the capture edge
// SHIFT | normalizing a subnormal one bit per cycle; inputs ignored
module fp16_unpack (
    input  logic              clk,
    input  logic              rst_n,
    fp16_unpack_if.slave      bus
);
    localparam logic [2:0] CLS_ZERO   = 3'd0;
    localparam logic [2:0] CLS_SUB    = 3'd1;
    localparam logic [2:0] CLS_NORMAL = 3'd2;
    localparam logic [2:0] CLS_INF    = 3'd3;
    localparam logic [2:0] CLS_QNAN   = 3'd4;
    localparam logic [2:0] CLS_SNAN   = 3'd5;

    function automatic logic [2:0] classify(input logic [4:0] e, input logic [9:0] m);
        if (e == 5'd0)
            return (m == 10'd0) ? CLS_ZERO : CLS_SUB;
        if (e == 5'd31) begin
            if (m == 10'd0) return CLS_INF;
            if (m[9])       return CLS_QNAN;
            return CLS_SNAN;
        end
        return CLS_NORMAL;
    endfunction

    logic [2:0]  cls_c;
    logic [6:0]  exp_c;
    logic [10:0] sig_c;

    logic        out_valid_r;
    logic        out_sign_r;
    logic [6:0]  out_exp_r;
    logic [10:0] out_sig_r;
    logic [2:0]  out_class_r;

    always_comb begin
        cls_c = classify(bus.in_exp, bus.in_mant);
        exp_c = '0;
        sig_c = '0;
        case (cls_c)
            CLS_NORMAL: begin
                exp_c = {2'b00, bus.in_exp} - 7'd15;
                sig_c = {1'b1, bus.in_mant};
            end
            CLS_INF, CLS_QNAN, CLS_SNAN: begin
                exp_c = 7'd16;
                sig_c = {1'b0, bus.in_mant};
            end
            default: ;
        endcase
`ifndef FP16_SUBNORM_NORMALIZE_EN
        if (cls_c == CLS_SUB)
            cls_c = CLS_ZERO;
`endif
    end

`ifdef FP16_SUBNORM_NORMALIZE_EN
    typedef enum logic [0:0] {IDLE, SHIFT} state_t;

    // Subnormal starting exponent is -14 (emin), stored in 7-bit two's complement.
    localparam logic [6:0] SUB_EXP0 = 7'h72;

    state_t      state;
    logic        busy_r;
    logic        sh_sign;
    logic [6:0]  sh_exp;
    logic [10:0] sh_sig;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy_r      <= 1'b0;
            sh_sign     <= 1'b0;
            sh_exp      <= '0;
            sh_sig      <= '0;
            out_valid_r <= 1'b0;
            out_sign_r  <= 1'b0;
            out_exp_r   <= '0;
            out_sig_r   <= '0;
            out_class_r <= '0;
        end else begin
            out_valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (cls_c == CLS_SUB) begin
                            sh_sign <= bus.in_sign;
                            sh_exp  <= SUB_EXP0;
                            sh_sig  <= {1'b0, bus.in_mant};
                            busy_r  <= 1'b1;
                            state   <= SHIFT;
                        end else begin
                            out_valid_r <= 1'b1;
                            out_sign_r  <= bus.in_sign;
                            out_exp_r   <= exp_c;
                            out_sig_r   <= sig_c;
                            out_class_r <= cls_c;
                        end
                    end
                end
                SHIFT: begin
                    sh_sig <= {sh_sig[9:0], 1'b0};
                    sh_exp <= sh_exp - 7'd1;
                    // Finish on the edge whose shift lands the leading one in the hidden-bit slot.
                    if (sh_sig[9]) begin
                        out_valid_r <= 1'b1;
                        out_sign_r  <= sh_sign;
                        out_exp_r   <= sh_exp - 7'd1;
                        out_sig_r   <= {sh_sig[9:0], 1'b0};
                        out_class_r <= CLS_SUB;
                        busy_r      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_r;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_sign_r  <= 1'b0;
            out_exp_r   <= '0;
            out_sig_r   <= '0;
            out_class_r <= '0;
        end else begin
            out_valid_r <= bus.in_valid;
            if (bus.in_valid) begin
                out_sign_r  <= bus.in_sign;
                out_exp_r   <= exp_c;
                out_sig_r   <= sig_c;
                out_class_r <= cls_c;
            end
        end
    end

    assign bus.busy = 1'b0;
`endif

    assign bus.out_valid = out_valid_r;
    assign bus.out_sign  = out_sign_r;
    assign bus.out_exp   = out_exp_r;
    assign bus.out_sig   = out_sig_r;
    assign bus.out_class = out_class_r;
endmodule

// File: tb/tb_fp16_unpack.sv
// Self-checking bench for fp16_unpack: directed table, hand sequences, randomized model check.
module tb_fp16_unpack;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    fp16_unpack_if bus ();

    fp16_unpack dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] h;
        logic        sign;
        logic [2:0]  cls;
        logic [6:0]  exp;
        logic [10:0] sig;
        int          lat;
        int          busy_cycles;
    } vec_t;

`ifdef FP16_SUBNORM_NORMALIZE_EN
    localparam bit NORM_ON = 1'b1;
`else
    localparam bit NORM_ON = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: value-level decode of an FP16 bit pattern.
    function automatic vec_t model(input logic [15:0] h);
        vec_t v;
        int   e;
        int   m;
        int   s;
        int   k;
        v.h = h;
        v.sign = h[15];
        v.cls = 3'd0;
        v.exp = 7'd0;
        v.sig = 11'd0;
        v.lat = 1;
        v.busy_cycles = 0;
        e = int'(h[14:10]);
        m = int'(h[9:0]);
        if (e == 0 && m == 0) begin
            v.cls = 3'd0;
        end else if (e == 0) begin
            if (NORM_ON) begin
                s = m;
                k = 0;
                while (s < 1024) begin
                    s = s * 2;
                    k++;
                end
                v.cls = 3'd1;
                v.exp = 7'(-14 - k);
                v.sig = 11'(s);
                v.lat = k + 1;
                v.busy_cycles = k;
            end
        end else if (e == 31) begin
            v.exp = 7'd16;
            v.sig = 11'(m);
            if (m == 0)        v.cls = 3'd3;
            else if (m >= 512) v.cls = 3'd4;
            else               v.cls = 3'd5;
        end else begin
            v.cls = 3'd2;
            v.exp = 7'(e - 15);
            v.sig = 11'(1024 + m);
        end
        return v;
    endfunction

    task automatic drive(input logic valid, input logic [15:0] h);
        bus.in_valid = valid;
        bus.in_sign  = h[15];
        bus.in_exp   = h[14:10];
        bus.in_mant  = h[9:0];
    endtask

    task automatic run_one(input string tag, input vec_t v);
        int   lat;
        int   bz;
        logic seen;
        @(negedge clk);
        drive(1'b1, v.h);
        lat = 0;
        bz = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            lat++;
            if (bus.busy) bz++;
            if (bus.out_valid) seen = 1'b1;
        end
        check({tag, ".valid_seen"}, 32'(seen), 32'd1);
        check({tag, ".latency"}, 32'(lat), 32'(v.lat));
        check({tag, ".busy_cycles"}, 32'(bz), 32'(v.busy_cycles));
        check({tag, ".sign"}, 32'(bus.out_sign), 32'(v.sign));
        check({tag, ".class"}, 32'(bus.out_class), 32'(v.cls));
        check({tag, ".exp"}, 32'(bus.out_exp), 32'(v.exp));
        check({tag, ".sig"}, 32'(bus.out_sig), 32'(v.sig));
        @(negedge clk);
        check({tag, ".pulse_width"}, 32'(bus.out_valid), 32'd0);
        check({tag, ".hold_sig"}, 32'(bus.out_sig), 32'(v.sig));
        check({tag, ".hold_class"}, 32'(bus.out_class), 32'(v.cls));
    endtask

    function automatic vec_t mk(input logic [15:0] h, input logic s, input logic [2:0] c,
                                input logic [6:0] e, input logic [10:0] g, input int l, input int b);
        vec_t v;
        v.h = h; v.sign = s; v.cls = c; v.exp = e; v.sig = g; v.lat = l; v.busy_cycles = b;
        return v;
    endfunction

    initial begin
        vec_t tbl [$];
        vec_t v;
        int   cnt;
        logic [15:0] h;

        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        drive(1'b0, 16'h0000);

        tbl.push_back(mk(16'h3C00, 1'b0, 3'd2, 7'h00, 11'h400, 1, 0));
        tbl.push_back(mk(16'h7C00, 1'b0, 3'd3, 7'h10, 11'h000, 1, 0));
        tbl.push_back(mk(16'h7E00, 1'b0, 3'd4, 7'h10, 11'h200, 1, 0));
        tbl.push_back(mk(16'h7C01, 1'b0, 3'd5, 7'h10, 11'h001, 1, 0));
        tbl.push_back(mk(16'hFE00, 1'b1, 3'd4, 7'h10, 11'h200, 1, 0));
        tbl.push_back(mk(16'h0000, 1'b0, 3'd0, 7'h00, 11'h000, 1, 0));
        tbl.push_back(mk(16'h8000, 1'b1, 3'd0, 7'h00, 11'h000, 1, 0));
        tbl.push_back(mk(16'hC000, 1'b1, 3'd2, 7'h01, 11'h400, 1, 0));
        tbl.push_back(mk(16'h7BFF, 1'b0, 3'd2, 7'h0F, 11'h7FF, 1, 0));
        tbl.push_back(mk(16'h0400, 1'b0, 3'd2, 7'h72, 11'h400, 1, 0));
`ifdef FP16_SUBNORM_NORMALIZE_EN
        tbl.push_back(mk(16'h8001, 1'b1, 3'd1, 7'h68, 11'h400, 11, 10));
        tbl.push_back(mk(16'h0200, 1'b0, 3'd1, 7'h71, 11'h400, 2, 1));
        tbl.push_back(mk(16'h03FF, 1'b0, 3'd1, 7'h71, 11'h7FE, 2, 1));
`else
        tbl.push_back(mk(16'h8001, 1'b1, 3'd0, 7'h00, 11'h000, 1, 0));
        tbl.push_back(mk(16'h0200, 1'b0, 3'd0, 7'h00, 11'h000, 1, 0));
        tbl.push_back(mk(16'h03FF, 1'b0, 3'd0, 7'h00, 11'h000, 1, 0));
`endif

        #12;
        check("reset.out_valid", 32'(bus.out_valid), 32'd0);
        check("reset.busy", 32'(bus.busy), 32'd0);
        check("reset.sig", 32'(bus.out_sig), 32'd0);
        check("reset.class", 32'(bus.out_class), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) run_one($sformatf("tbl%0d_%04h", i, tbl[i].h), tbl[i]);

        // Second pulse arrives while the first operand is still normalizing.
        @(negedge clk);
        drive(1'b1, 16'h0001);
        cnt = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.out_valid) cnt++;
            if (c == 3) drive(1'b1, 16'h3C00);
            else        bus.in_valid = 1'b0;
        end
        check("drop.pulse_count", 32'(cnt), NORM_ON ? 32'd1 : 32'd2);
        check("drop.class", 32'(bus.out_class), NORM_ON ? 32'd1 : 32'd2);
        check("drop.exp", 32'(bus.out_exp), NORM_ON ? 32'h68 : 32'h00);

        // Back-to-back: operand presented in the same cycle out_valid is high.
        @(negedge clk);
        drive(1'b1, 16'h0200);
        cnt = 0;
        while (!bus.out_valid && cnt < 20) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            cnt++;
        end
        check("b2b.first_seen", 32'(bus.out_valid), 32'd1);
        drive(1'b1, 16'hC000);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("b2b.second_valid", 32'(bus.out_valid), 32'd1);
        check("b2b.second_exp", 32'(bus.out_exp), 32'h01);
        check("b2b.second_sign", 32'(bus.out_sign), 32'd1);

        // Reset in the middle of a normalization, then operand on the first edge after release.
        @(negedge clk);
        drive(1'b1, 16'h0001);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("midrst.busy", 32'(bus.busy), 32'd0);
        check("midrst.out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst.fields", {bus.out_sign, bus.out_exp, bus.out_sig, bus.out_class}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 16'h3C00);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("postrst.valid", 32'(bus.out_valid), 32'd1);
        check("postrst.class", 32'(bus.out_class), 32'd2);
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.out_valid) cnt++;
        end
        check("midrst.no_late_valid", 32'(cnt), 32'd0);

        for (int n = 0; n < 200; n++) begin
            h = 16'($urandom);
            if ($urandom_range(0, 2) == 0) h[14:10] = 5'd0;
            else if ($urandom_range(0, 5) == 0) h[14:10] = 5'd31;
            v = model(h);
            run_one($sformatf("rnd_%04h", h), v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
